// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button conditioning block.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int REPEAT_CYCLES_DEF   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Metastability filter: first flop may go metastable, second presents a settled value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchroniser, debounce counter and acceptance FSM with
// registered level/press/release outputs. Auto-repeat is built with BUTTON_DEBOUNCE_AUTOREPEAT_EN.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_r;
`endif

    logic          btn_sync_s;
    btn_state_e    state_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;
    logic          release_r;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync_s)
    );

    // Acceptance FSM: an edge is taken only after DEBOUNCE_CYCLES further stable samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
            rpt_r     <= '0;
`endif
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (btn_sync_s) begin
                        state_r <= PRESS_WAIT;
                        cnt_r   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync_s) begin
                        state_r <= IDLE;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= HELD;
                        level_r <= 1'b1;
                        press_r <= 1'b1;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                        rpt_r   <= '0;
`endif
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_sync_s) begin
                        state_r <= RELEASE_WAIT;
                        cnt_r   <= '0;
                    end else begin
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                        // Repeat phase only advances while the button is steadily held.
                        if (rpt_r == RPT_MAX) begin
                            press_r <= 1'b1;
                            rpt_r   <= '0;
                        end else begin
                            rpt_r <= rpt_r + 1'b1;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync_s) begin
                        state_r <= HELD;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r   <= IDLE;
                        level_r   <= 1'b0;
                        release_r <= 1'b1;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                        rpt_r     <= '0;
`endif
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a run-length reference model predicts each cycle's outputs.
module tb_button_debounce;

    localparam int D = 16;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, btn_press, btn_release;

    always #5 clk = ~clk;

    button_debounce dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
    } exp_t;

    exp_t exp_q[$];
    int   press_edges[$];
    int   rel_edges[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_no = 0;
    int   level_rise_edge = -1;
    logic prev_level = 1'b0;

    // reference model: raw history (two-sample lag), accepted level, run of disagreeing samples
    bit m_h1, m_h2, m_level;
    int m_run, m_hold;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // one clock of stimulus; the model's prediction for the coming edge goes to the scoreboard
    task automatic tick(input bit raw, input bit rv);
        exp_t e;
        bit   s;
        @(negedge clk);
        rst     = rv;
        btn_raw = raw;
        edge_no++;
        e = '0;
        if (!rv) begin
            m_h1 = 1'b0; m_h2 = 1'b0; m_level = 1'b0; m_run = 0; m_hold = 0;
        end else begin
            s    = m_h2;
            m_h2 = m_h1;
            m_h1 = raw;
            if (s != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = s;
                    m_run   = 0;
                    m_hold  = 0;
                    if (s) e.press = 1'b1;
                    else   e.rel   = 1'b1;
                end
            end else begin
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                if (m_level && m_run == 0) begin
                    m_hold++;
                    if (m_hold == R) begin
                        e.press = 1'b1;
                        m_hold  = 0;
                    end
                end
`endif
                m_run = 0;
            end
        end
        e.level = m_level;
        exp_q.push_back(e);
    endtask

    task automatic clear_logs();
        press_edges.delete();
        rel_edges.delete();
        level_rise_edge = -1;
    endtask

    // monitor: pop one prediction per edge and compare against the registered outputs
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("level", int'(btn_level), int'(e.level));
            check("press", int'(btn_press), int'(e.press));
            check("release", int'(btn_release), int'(e.rel));
            check("press_release_excl", int'(btn_press & btn_release), 0);
            if (btn_press) press_edges.push_back(edge_no);
            if (btn_release) rel_edges.push_back(edge_no);
            if (btn_level && !prev_level) level_rise_edge = edge_no;
            prev_level = btn_level;
        end
    end

    initial begin
        int start;
        int rel_start;
        int len;
        int guard;
        bit v;
        bit rv;

        // reset held with the button already pressed
        clear_logs();
        repeat (3) begin
            tick(1'b1, 1'b0);
            #1 check("reset_outputs", int'({btn_level, btn_press, btn_release}), 0);
        end
        start = edge_no + 1;
        repeat (D + 8) tick(1'b1, 1'b1);
        check("post_reset_level_edge", level_rise_edge, start + D + 2);
        repeat (D + 6) tick(1'b0, 1'b1);

        // clean press held 40 cycles past acceptance, then full release
        clear_logs();
        start = edge_no + 1;
        repeat (D + 2 + 40) tick(1'b1, 1'b1);
        rel_start = edge_no + 1;
        repeat (D + 6) tick(1'b0, 1'b1);
        check("press_level_edge", level_rise_edge, start + D + 2);
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
        check("repeat_count_ge5", int'(press_edges.size() >= 5), 1);
        for (int k = 0; k < 5; k++) begin
            if (press_edges.size() > k) check("repeat_edge", press_edges[k], start + D + 2 + k * R);
        end
`else
        check("press_count", press_edges.size(), 1);
        if (press_edges.size() > 0) check("press_edge", press_edges[0], start + D + 2);
`endif
        check("release_count", rel_edges.size(), 1);
        if (rel_edges.size() > 0) check("release_edge", rel_edges[0], rel_start + D + 2);

        // bouncing input: 5-cycle pulses never qualify
        clear_logs();
        repeat (6) begin
            repeat (5) tick(1'b1, 1'b1);
            repeat (5) tick(1'b0, 1'b1);
        end
        repeat (5) tick(1'b0, 1'b1);
        check("bounce_press_count", press_edges.size(), 0);
        check("bounce_release_count", rel_edges.size(), 0);
        check("bounce_level_rise", level_rise_edge, -1);

        // release bounce while held
        repeat (D + 8) tick(1'b1, 1'b1);
        clear_logs();
        repeat (10) tick(1'b0, 1'b1);
        repeat (10) tick(1'b1, 1'b1);
        #1 check("rel_bounce_level", int'(btn_level), 1);
        check("rel_bounce_release_count", rel_edges.size(), 0);
`ifndef BUTTON_DEBOUNCE_AUTOREPEAT_EN
        check("rel_bounce_press_count", press_edges.size(), 0);
`endif
        repeat (D + 6) tick(1'b0, 1'b1);
        check("full_release_count", rel_edges.size(), 1);

        // reset in PRESS_WAIT with cnt at 8, then re-debounce the still-pressed button
        clear_logs();
        repeat (11) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        #1 check("rst_in_press_wait", int'({btn_level, btn_press, btn_release}), 0);
        tick(1'b1, 1'b0);
        start = edge_no + 1;
        repeat (D + 6) tick(1'b1, 1'b1);
        check("redebounce_level_edge", level_rise_edge, start + D + 2);

        // reset in HELD: immediate clear, never a release strobe
        clear_logs();
        tick(1'b1, 1'b0);
        #1 check("rst_in_held", int'({btn_level, btn_press, btn_release}), 0);
        tick(1'b1, 1'b0);
        repeat (D + 6) tick(1'b0, 1'b1);
        check("rst_held_release_count", rel_edges.size(), 0);

        // random runs with occasional resets
        repeat (60) begin
            v   = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 15) != 0);
            len = rv ? $urandom_range(1, 2 * D + 4) : $urandom_range(1, 3);
            repeat (len) tick(v, rv);
        end
        repeat (3) tick(1'b0, 1'b1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
